// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wb_arbiter
//  Description : Two-port (ALU / load unit) round-robin writeback arbiter
//                feeding a single register-file write port, with a per-
//                register pending-write scoreboard for hazard queries.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
   parameter int XLEN = 32,
   parameter int NREG = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   // ALU writeback request
   input  logic            a_valid,
   input  logic [4:0]      a_rd,
   input  logic [XLEN-1:0] a_data,
   output logic            a_ready,
   // Load-unit writeback request
   input  logic            b_valid,
   input  logic [4:0]      b_rd,
   input  logic [XLEN-1:0] b_data,
   output logic            b_ready,
   // Issue-side scoreboard update
   input  logic            iss_valid,
   input  logic [4:0]      iss_rd,
   // Hazard queries
   input  logic [4:0]      rs1,
   input  logic [4:0]      rs2,
   output logic            hz_rs1,
   output logic            hz_rs2,
   // Register-file write port
   output logic            wr_en,
   output logic [4:0]      wr_rd,
   output logic [XLEN-1:0] wr_data
);

   localparam logic [4:0] c_RD_ZERO = 5'd0;

   logic            r_last_b;   // 1: b was granted most recently
   logic            r_wr_en;
   logic [4:0]      r_wr_rd;
   logic [XLEN-1:0] r_wr_data;
   logic [NREG-1:0] r_pend;
   logic [NREG-1:0] w_pend_nxt;

   logic            w_gnt_a;
   logic            w_gnt_b;
   logic            w_hs_a;
   logic            w_hs_b;
   logic [4:0]      w_sel_rd;
   logic [XLEN-1:0] w_sel_data;

   // Grant: sole requester wins; under contention the side not granted last wins.
   // Readies are forced low while reset is held.
   assign w_gnt_a = a_valid & (~b_valid | r_last_b);
   assign w_gnt_b = b_valid & (~a_valid | ~r_last_b);
   assign a_ready = w_gnt_a & rst_n;
   assign b_ready = w_gnt_b & rst_n;
   assign w_hs_a  = a_valid & a_ready;
   assign w_hs_b  = b_valid & b_ready;

   assign w_sel_rd   = w_hs_a ? a_rd   : b_rd;
   assign w_sel_data = w_hs_a ? a_data : b_data;

   // Register the accepted request onto the write port and advance the pointer.
   // Writes to x0 are accepted (pointer moves) but never reach the write port.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last_b  <= 1'b1;
         r_wr_en   <= 1'b0;
         r_wr_rd   <= '0;
         r_wr_data <= '0;
      end else begin
         r_wr_en <= 1'b0;
         if (w_hs_a || w_hs_b) begin
            r_last_b <= w_hs_b;
            if (w_sel_rd != c_RD_ZERO) begin
               r_wr_en   <= 1'b1;
               r_wr_rd   <= w_sel_rd;
               r_wr_data <= w_sel_data;
            end
         end
      end
   end

   // Scoreboard next state: clear on writeback, then set on issue so set wins.
   always_comb begin
      w_pend_nxt = r_pend;
      if (r_wr_en) begin
         w_pend_nxt[r_wr_rd] = 1'b0;
      end
      if (iss_valid && (iss_rd != c_RD_ZERO)) begin
         w_pend_nxt[iss_rd] = 1'b1;
      end
      w_pend_nxt[0] = 1'b0;
   end

   // Scoreboard state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pend <= '0;
      end else begin
         r_pend <= w_pend_nxt;
      end
   end

   // Hazards reflect the registered scoreboard only; the in-flight write is not bypassed.
   assign hz_rs1 = r_pend[rs1];
   assign hz_rs2 = r_pend[rs2];

   assign wr_en   = r_wr_en;
   assign wr_rd   = r_wr_rd;
   assign wr_data = r_wr_data;

endmodule
`default_nettype wire

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width of register writes.
REQ-002 SHALL have parameter NREG, default 32, number of architectural registers (index width 5).
REQ-003 SHALL have port clk  input  1  clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port a_valid  input  1  ALU writeback request.
REQ-006 SHALL have port a_rd  input  5  ALU destination register.
REQ-007 SHALL have port a_data  input  XLEN  ALU result.
REQ-008 SHALL have port a_ready  output  1  ALU request accepted this cycle.
REQ-009 SHALL have port b_valid, b_rd, b_data, b_ready with the same widths and meaning for the load unit.
REQ-010 SHALL have port iss_valid  input  1  an instruction with a register destination issues this cycle.
REQ-011 SHALL have port iss_rd  input  5  destination of the issuing instruction.
REQ-012 SHALL have port rs1, rs2  input  5 each  source registers queried for hazards.
REQ-013 SHALL have port hz_rs1, hz_rs2  output  1 each  queried source has a pending write.
REQ-014 SHALL have port wr_en, wr_rd, wr_data  output  1/5/XLEN  register-file write port.

Function
REQ-015 SHALL grant at most one of a/b per cycle; grant is combinational from a_valid, b_valid and the last-grant pointer.
REQ-016 SHALL grant the sole valid requester when only one is valid.
REQ-017 SHALL, when both are valid, grant the requester not granted last (round-robin); pointer updates only on an accepted handshake.
REQ-018 SHALL assert x_ready only together with x_valid and grant; handshake = x_valid & x_ready.
REQ-019 SHALL register the accepted request: accept in cycle N -> wr_en=1, wr_rd, wr_data presented in cycle N+1.
REQ-020 SHALL drive wr_en=0 in cycle N+1 when no handshake occurred in cycle N; wr_rd/wr_data hold previous values.
REQ-021 SHALL accept requests with rd=0 (ready asserted, pointer updated) but SHALL NOT assert wr_en for them.
REQ-022 SHALL keep a pending bit per register; iss_valid with iss_rd!=0 sets pend[iss_rd] at the clock edge.
REQ-023 SHALL clear pend[wr_rd] at the clock edge where wr_en=1.
REQ-024 SHALL, when set and clear target the same register on the same edge, leave the bit set (set wins).
REQ-025 SHALL never set pend[0]; hz for index 0 SHALL always be 0.
REQ-026 SHALL drive hz_rs1=pend[rs1], hz_rs2=pend[rs2] combinationally; no bypass of the in-flight wr_en write.
REQ-027 SHALL not block or reorder a request whose rd is not pending; writes are forwarded regardless of pend state.

Reset
REQ-028 SHALL, on rst_n low at any time, immediately clear wr_en, wr_rd, wr_data, all pending bits, and set pointer to "b last" so a wins first contention.
REQ-029 SHALL drop a request accepted in the cycle reset asserts; no write emerges after reset release.
REQ-030 SHALL hold a_ready=b_ready=0 while rst_n is low.

Verification
REQ-031 Both valid from reset, a_rd=3/a_data=0x11, b_rd=4/b_data=0x22, held 2 cycles -> wr_en cycles 2,3 writing x3=0x11 then x4=0x22.
REQ-032 Only b_valid, b_rd=7, data 0xDEADBEEF -> b_ready same cycle, next cycle wr_en=1, wr_rd=7, wr_data=0xDEADBEEF.
REQ-033 iss_valid iss_rd=5, then rs1=5 -> hz_rs1=1; a writes rd=5 -> hz_rs1=0 after the edge where wr_en=1.
REQ-034 iss_rd=6 issued on the same edge wr_en=1 wr_rd=6 -> pend[6] remains 1, hz=1.
REQ-035 a_valid with a_rd=0, data 0x55 -> a_ready=1, wr_en stays 0; iss_rd=0 -> hz for rs1=0 stays 0.
REQ-036 Assert rst_n low mid-stream with pend[9]=1 and wr_en=1 -> wr_en=0, hz for rs1=9 is 0 immediately, next contention grants a.
